// File: rtl/div_clk_monitor_if.sv
// Signal bundle between a divided-clock source/consumer (master) and div_clk_monitor (slave).
// clk_in is a free-running level, err_clr a single-cycle pulse; no valid/ready, every output is a registered level or strobe.
interface div_clk_monitor_if #(
    parameter int CNT_W = 16
);
    logic             clk_in;
    logic             err_clr;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] half_count;
    logic             locked;
    logic             err;
    logic [1:0]       state_dbg;   // 0 = IDLE, 1 = MEAS, 2 = LOCKED

    modport master (
        output clk_in, err_clr,
        input  rise_pulse, fall_pulse, half_count, locked, err, state_dbg
    );

    modport slave (
        input  clk_in, err_clr,
        output rise_pulse, fall_pulse, half_count, locked, err, state_dbg
    );
endinterface

// File: rtl/div_clk_monitor.sv
// Synchronizes a divided clock into sysclk, emits rise/fall strobes and checks each
// half-period against HALF_PERIOD +/- TOL, reporting lock and sticky frequency errors.
module div_clk_monitor #(
    parameter int HALF_PERIOD = 500,
    parameter int TOL         = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int CNT_W       = 16
) (
    input logic              sysclk,
    input logic              reset,
    div_clk_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEAS   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Window limits are one bit wider than the counter so the low bound cannot underflow.
    localparam logic [CNT_W:0]   HP_W    = (CNT_W + 1)'(HALF_PERIOD);
    localparam logic [CNT_W:0]   TOL_W   = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W:0]   HI_W    = (CNT_W + 1)'(HALF_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(HALF_PERIOD + TOL + 1);
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic             rise_q, rise_d, fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [3:0]       good_q, good_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    state_e           state_q, state_d;

    logic             edge_seen;
    logic             in_tol;
    logic             timeout;
    logic             err_set;
    logic [CNT_W:0]   meas_ext;

    always_comb begin
        s1_d      = bus.clk_in;
        s2_d      = s1_q;
        s3_d      = s2_q;
        edge_seen = s2_q ^ s3_q;
        rise_d    = s2_q & ~s3_q;
        fall_d    = ~s2_q & s3_q;

        meas_ext  = {1'b0, cnt_q};
        in_tol    = ((meas_ext + TOL_W) >= HP_W) && (meas_ext <= HI_W);
        // An edge on the same cycle always wins: that interval is measured, not timed out.
        timeout   = !edge_seen && (cnt_q == TO_CNT);

        if (edge_seen) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        state_d  = state_q;
        half_d   = half_q;
        good_d   = good_q;
        locked_d = locked_q;
        err_set  = 1'b0;

        case (state_q)
            IDLE: begin
                // First interval after (re)start is partial and is thrown away.
                good_d = 4'd0;
                if (edge_seen) begin
                    state_d = MEAS;
                end
            end
            MEAS: begin
                if (edge_seen) begin
                    half_d = cnt_q;
                    if (in_tol) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_N) begin
                            locked_d = 1'b1;
                            state_d  = LOCKED;
                        end
                    end else begin
                        good_d = 4'd0;
                    end
                end else if (timeout) begin
                    good_d  = 4'd0;
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (edge_seen) begin
                    half_d = cnt_q;
                    if (!in_tol) begin
                        err_set  = 1'b1;
                        locked_d = 1'b0;
                        good_d   = 4'd0;
                        state_d  = MEAS;
                    end
                end else if (timeout) begin
                    err_set  = 1'b1;
                    locked_d = 1'b0;
                    good_d   = 4'd0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_set) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
            half_q   <= '0;
            good_q   <= 4'd0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= IDLE;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            state_q  <= state_d;
        end
    end

    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.half_count = half_q;
    assign bus.locked     = locked_q;
    assign bus.err        = err_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: drives clk_in as a sequence of half-periods and checks
// strobes and status against an interval-level model of the lock/error rules.
module tb_div_clk_monitor;
  localparam int HP         = 500;
  localparam int TOL        = 2;
  localparam int LOCK_COUNT = 4;
  localparam int CNT_W      = 16;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;

  div_clk_monitor_if #(.CNT_W(CNT_W)) bus();

  div_clk_monitor #(
    .HALF_PERIOD(HP),
    .TOL(TOL),
    .LOCK_COUNT(LOCK_COUNT),
    .CNT_W(CNT_W)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model (one step per clk_in edge) ----------------
  // m_mode: 0 waiting for a first edge, 1 measuring, 2 locked
  int  m_mode   = 0;
  int  m_run    = 0;
  int  m_half   = 0;
  int  prev_len = 0;
  bit  m_locked = 1'b0;
  bit  m_err    = 1'b0;
  logic [CNT_W-1:0] exp_q[$];

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_half = 0; m_locked = 1'b0; m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge(input int len, output bit set_err);
    set_err = 1'b0;
    if (m_mode == 0) begin
      m_mode = 1;
      return;
    end
    m_half = len;
    exp_q.push_back(CNT_W'(len));
    if (len >= HP - TOL && len <= HP + TOL) begin
      if (m_mode == 1) begin
        m_run++;
        if (m_run == LOCK_COUNT) begin
          m_locked = 1'b1;
          m_mode   = 2;
        end
      end
    end else begin
      if (m_mode == 2) begin
        m_err    = 1'b1;
        set_err  = 1'b1;
        m_locked = 1'b0;
      end
      m_run  = 0;
      m_mode = 1;
    end
  endtask

  task automatic model_timeout();
    if (m_mode != 0) begin
      if (m_mode == 2) begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end
      m_run  = 0;
      m_mode = 0;
    end
  endtask

  // ---------------- driver ----------------
  // One half-period of clk_in lasting len sysclk cycles. clr_at / rst_at pulse
  // err_clr / assert reset after that cycle index (0 = never). tog=0 means the
  // edge comes from a reset release with clk_in already high.
  task automatic do_half(input int len, input int clr_at, input int rst_at, input bit tog);
    bit edge_set, pend, exp_r, exp_f;
    logic [CNT_W+3:0] old_stat, exp_stat, got_stat;
    logic [CNT_W-1:0] exp_h;
    if (tog) bus.clk_in = ~bus.clk_in;
    old_stat = {2'(m_mode), m_locked, m_err, CNT_W'(m_half)};
    model_edge(prev_len, edge_set);
    prev_len = len;
    for (int i = 1; i <= len; i++) begin
      @(posedge sysclk);
      #1;
      bus.err_clr = (i == clr_at);
      if (rst_at > 0 && i == rst_at) reset = 1'b1;
      if (rst_at > 0 && i == rst_at + 1) model_reset();
      if (clr_at > 0 && i == clr_at + 1 && !(clr_at == 2 && edge_set)) m_err = 1'b0;
      if (i == HP + TOL + 4) model_timeout();

      pend  = (i == 3) && !(rst_at > 0 && rst_at < 3);
      exp_r = pend && bus.clk_in;
      exp_f = pend && !bus.clk_in;
      n_checks++;
      if (bus.rise_pulse !== exp_r || bus.fall_pulse !== exp_f)
        $display("FAIL strobe cycle=%0d: got rise=%b fall=%b, expected rise=%b fall=%b",
                 i, bus.rise_pulse, bus.fall_pulse, exp_r, exp_f);
      else n_pass++;

      if (i == 3 && exp_q.size() > 0) begin
        exp_h = exp_q.pop_front();
        n_checks++;
        if (bus.half_count !== exp_h)
          $display("FAIL half_count: got %0d, expected %0d", bus.half_count, exp_h);
        else n_pass++;
      end

      if (i == 2 || i == 3 || i == HP + TOL + 3 || i == HP + TOL + 4 || i == len) begin
        exp_stat = (i == 2) ? old_stat : {2'(m_mode), m_locked, m_err, CNT_W'(m_half)};
        got_stat = {bus.state_dbg, bus.locked, bus.err, bus.half_count};
        n_checks++;
        if (got_stat !== exp_stat)
          $display("FAIL status cycle=%0d len=%0d: got state=%0d locked=%b err=%b half=%0d, expected state=%0d locked=%b err=%b half=%0d",
                   i, len, got_stat[CNT_W+3:CNT_W+2], got_stat[CNT_W+1], got_stat[CNT_W],
                   got_stat[CNT_W-1:0], exp_stat[CNT_W+3:CNT_W+2], exp_stat[CNT_W+1],
                   exp_stat[CNT_W], exp_stat[CNT_W-1:0]);
        else n_pass++;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.clk_in  = 1'b0;
    bus.err_clr = 1'b0;
    reset       = 1'b1;
    repeat (5) @(posedge sysclk);
    #1;
    n_checks++;
    if ({bus.rise_pulse, bus.fall_pulse, bus.locked, bus.err} !== 4'b0000)
      $display("FAIL reset_flags: got rise=%b fall=%b locked=%b err=%b, expected all 0",
               bus.rise_pulse, bus.fall_pulse, bus.locked, bus.err);
    else n_pass++;
    n_checks++;
    if (bus.half_count !== '0 || bus.state_dbg !== 2'd0)
      $display("FAIL reset_count: got half=%0d state=%0d, expected 0 0", bus.half_count, bus.state_dbg);
    else n_pass++;
    reset = 1'b0;
    model_reset();
    prev_len = 0;
  endtask

  task automatic test_lock();
    for (int k = 1; k <= 4; k++) do_half(HP, 0, 0, 1'b1);
    n_checks++;
    if (bus.locked !== 1'b0) $display("FAIL lock_early: got locked=%b, expected 0", bus.locked);
    else n_pass++;
    do_half(HP, 0, 0, 1'b1);
    n_checks++;
    if (bus.locked !== 1'b1 || bus.half_count !== 16'd500 || bus.err !== 1'b0)
      $display("FAIL lock: got locked=%b half=%0d err=%b, expected 1 500 0", bus.locked, bus.half_count, bus.err);
    else n_pass++;
  endtask

  task automatic test_tolerance();
    do_half(502, 0, 0, 1'b1);
    do_half(498, 0, 0, 1'b1);
    n_checks++;
    if (bus.half_count !== 16'd502 || bus.locked !== 1'b1)
      $display("FAIL tol_hi: got half=%0d locked=%b, expected 502 1", bus.half_count, bus.locked);
    else n_pass++;
    do_half(HP, 0, 0, 1'b1);
    n_checks++;
    if (bus.half_count !== 16'd498 || bus.locked !== 1'b1 || bus.err !== 1'b0)
      $display("FAIL tol_lo: got half=%0d locked=%b err=%b, expected 498 1 0", bus.half_count, bus.locked, bus.err);
    else n_pass++;
  endtask

  task automatic test_bad_half();
    do_half(503, 0, 0, 1'b1);
    do_half(HP, 0, 0, 1'b1);
    n_checks++;
    if (bus.locked !== 1'b0 || bus.err !== 1'b1 || bus.half_count !== 16'd503 || bus.state_dbg !== 2'd1)
      $display("FAIL bad_half: got locked=%b err=%b half=%0d state=%0d, expected 0 1 503 1",
               bus.locked, bus.err, bus.half_count, bus.state_dbg);
    else n_pass++;
    for (int k = 0; k < 4; k++) do_half(HP, 0, 0, 1'b1);
    n_checks++;
    if (bus.locked !== 1'b1 || bus.err !== 1'b1)
      $display("FAIL relock: got locked=%b err=%b, expected 1 1", bus.locked, bus.err);
    else n_pass++;
    do_half(HP, 50, 0, 1'b1);
    n_checks++;
    if (bus.err !== 1'b0) $display("FAIL err_clr: got err=%b, expected 0", bus.err);
    else n_pass++;
  endtask

  task automatic test_freeze();
    do_half(700, 0, 0, 1'b1);
    n_checks++;
    if (bus.locked !== 1'b0 || bus.err !== 1'b1 || bus.state_dbg !== 2'd0 || bus.half_count !== 16'd500)
      $display("FAIL freeze: got locked=%b err=%b state=%0d half=%0d, expected 0 1 0 500",
               bus.locked, bus.err, bus.state_dbg, bus.half_count);
    else n_pass++;
    for (int k = 0; k < 5; k++) do_half(HP, 0, 0, 1'b1);
    n_checks++;
    if (bus.locked !== 1'b1) $display("FAIL freeze_relock: got locked=%b, expected 1", bus.locked);
    else n_pass++;
    do_half(HP, 50, 0, 1'b1);
  endtask

  task automatic test_clr_collision();
    do_half(490, 0, 0, 1'b1);
    do_half(HP, 2, 0, 1'b1);
    n_checks++;
    if (bus.err !== 1'b1 || bus.locked !== 1'b0)
      $display("FAIL clr_collision: got err=%b locked=%b, expected 1 0", bus.err, bus.locked);
    else n_pass++;
    for (int k = 0; k < 4; k++) do_half(HP, 0, 0, 1'b1);
    do_half(HP, 50, 0, 1'b1);
    n_checks++;
    if (bus.err !== 1'b0 || bus.locked !== 1'b1)
      $display("FAIL clr_after: got err=%b locked=%b, expected 0 1", bus.err, bus.locked);
    else n_pass++;
  endtask

  task automatic test_random();
    int len, sel, clr;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      len = $urandom_range(HP - TOL, HP + TOL);
      else if (sel < 9) len = $urandom_range(490, 503);
      else              len = 600;
      clr = 0;
      if ($urandom_range(0, 3) == 0) clr = ($urandom_range(0, 1) == 0) ? 2 : 50;
      do_half(len, clr, 0, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 6; k++) do_half(HP, 0, 0, 1'b1);
    if (bus.clk_in) do_half(HP, 0, 0, 1'b1);
    n_checks++;
    if (bus.locked !== 1'b1) $display("FAIL pre_reset_lock: got locked=%b, expected 1", bus.locked);
    else n_pass++;
    do_half(20, 0, 2, 1'b1);
    n_checks++;
    if ({bus.rise_pulse, bus.fall_pulse, bus.locked, bus.err} !== 4'b0000 || bus.half_count !== '0)
      $display("FAIL mid_reset: got rise=%b fall=%b locked=%b err=%b half=%0d, expected all 0",
               bus.rise_pulse, bus.fall_pulse, bus.locked, bus.err, bus.half_count);
    else n_pass++;
    reset = 1'b0;
    do_half(HP, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) do_half(HP, 0, 0, 1'b1);
    n_checks++;
    if (bus.locked !== 1'b1 || bus.err !== 1'b0)
      $display("FAIL post_reset_lock: got locked=%b err=%b, expected 1 0", bus.locked, bus.err);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lock();
    test_tolerance();
    test_bad_half();
    test_freeze();
    test_clr_collision();
    test_random();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() > 1)
      $display("FAIL scoreboard_drain: %0d measurements left, expected at most 1", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
